// File: rtl/mem_lsu.sv
// mem_lsu: pipelined MEM-stage load/store unit with in-order tracking FIFO and address-error detection.
// Optional LSU_KSEG_MAP_EN maps kseg0/kseg1 virtual addresses to physical addresses.
module mem_lsu #(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [2:0]                issue_op,
  input  logic [31:0]               issue_addr,
  input  logic [31:0]               issue_wdata,
  input  logic [REG_ADDR_W-1:0]     issue_wd,
  input  logic                      flush,
  output logic                      data_req,
  output logic                      data_wr,
  output logic [1:0]                data_size,
  output logic [31:0]               data_addr,
  output logic [31:0]               data_wdata,
  input  logic [31:0]               data_rdata,
  input  logic                      data_addr_ok,
  input  logic                      data_data_ok,
  output logic                      resp_valid,
  output logic                      resp_wreg,
  output logic [REG_ADDR_W-1:0]     resp_wd,
  output logic [31:0]               resp_wdata,
  output logic                      exc_valid,
  output logic [4:0]                exc_code,
  output logic [31:0]               exc_badvaddr,
  output logic [$clog2(DEPTH):0]    outstanding
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [2:0]            op_q [DEPTH];
  logic [1:0]            a_q  [DEPTH];
  logic [REG_ADDR_W-1:0] wd_q [DEPTH];
  logic [DEPTH-1:0]      kill_q;
  logic [PW-1:0]         wp_q, rp_q;
  logic [CW-1:0]         cnt_q;
  logic                  resp_valid_q, resp_wreg_q, exc_valid_q;
  logic [REG_ADDR_W-1:0] resp_wd_q;
  logic [31:0]           resp_wdata_q, exc_badvaddr_q;
  logic [4:0]            exc_code_q;

  logic        aligned, push, pop, mis_acc, resp_d;
  logic [2:0]  sel_op;
  logic [1:0]  sel_a;
  logic [7:0]  rb;
  logic [15:0] rh;
  logic [31:0] ext;

  always_comb begin
    aligned     = (issue_op == 3'd4 || issue_op == 3'd7) ? (issue_addr[1:0] == 2'b00) :
                  (issue_op == 3'd2 || issue_op == 3'd3 || issue_op == 3'd6) ? !issue_addr[0] : 1'b1;
    data_req    = issue_valid & aligned & (cnt_q != CW'(DEPTH)) & !flush;
    push        = data_req & data_addr_ok;
    pop         = data_data_ok & (cnt_q != '0);
    mis_acc     = issue_valid & !aligned & (cnt_q == '0) & !flush;
    issue_ready = aligned ? push : mis_acc;
    data_wr     = issue_op >= 3'd5;
    data_size   = (issue_op == 3'd0 || issue_op == 3'd1 || issue_op == 3'd5) ? 2'd0 :
                  (issue_op == 3'd2 || issue_op == 3'd3 || issue_op == 3'd6) ? 2'd1 : 2'd2;
    data_wdata  = (data_size == 2'd0) ? {4{issue_wdata[7:0]}} :
                  (data_size == 2'd1) ? {2{issue_wdata[15:0]}} : issue_wdata;
`ifdef LSU_KSEG_MAP_EN
    data_addr   = (issue_addr[31:30] == 2'b10) ? {3'b000, issue_addr[28:0]} : issue_addr;
`else
    data_addr   = issue_addr;
`endif
    sel_op      = op_q[rp_q];
    sel_a       = a_q[rp_q];
    rb          = 8'(data_rdata >> {sel_a, 3'b000});
    rh          = 16'(data_rdata >> {sel_a[1], 4'b0000});
    ext         = (sel_op == 3'd0) ? {{24{rb[7]}}, rb} :
                  (sel_op == 3'd1) ? {24'b0, rb} :
                  (sel_op == 3'd2) ? {{16{rh[15]}}, rh} :
                  (sel_op == 3'd3) ? {16'b0, rh} : data_rdata;
    resp_d      = pop & !kill_q[rp_q] & !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0;
        a_q[i]  <= '0;
        wd_q[i] <= '0;
      end
      kill_q         <= '0;
      wp_q           <= '0;
      rp_q           <= '0;
      cnt_q          <= '0;
      resp_valid_q   <= 1'b0;
      resp_wreg_q    <= 1'b0;
      resp_wd_q      <= '0;
      resp_wdata_q   <= '0;
      exc_valid_q    <= 1'b0;
      exc_code_q     <= '0;
      exc_badvaddr_q <= '0;
    end else begin
      kill_q <= flush ? '1 : kill_q;
      if (push) begin
        op_q[wp_q]   <= issue_op;
        a_q[wp_q]    <= issue_addr[1:0];
        wd_q[wp_q]   <= issue_wd;
        kill_q[wp_q] <= 1'b0;
        wp_q         <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q        <= cnt_q + CW'(push) - CW'(pop);
      resp_valid_q <= resp_d;
      if (resp_d) begin
        resp_wreg_q  <= sel_op < 3'd5;
        resp_wd_q    <= wd_q[rp_q];
        resp_wdata_q <= ext;
      end
      exc_valid_q <= mis_acc;
      if (mis_acc) begin
        exc_code_q     <= data_wr ? 5'd5 : 5'd4;
        exc_badvaddr_q <= issue_addr;
      end
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_wreg    = resp_wreg_q;
  assign resp_wd      = resp_wd_q;
  assign resp_wdata   = resp_wdata_q;
  assign exc_valid    = exc_valid_q;
  assign exc_code     = exc_code_q;
  assign exc_badvaddr = exc_badvaddr_q;
  assign outstanding  = cnt_q;
endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Pipelined load/store unit for the MEM stage. It accepts in-order load and store operations from EX and issues them on the SRAM-like data bus (req/addr_ok/data_ok). It supports up to DEPTH outstanding transactions, detects misaligned addresses and reports AdEL/AdES, and returns in-order write-back responses with byte and halfword extraction. A flush input discards the results of all in-flight transactions.

Parameters:
DEPTH, 4, maximum outstanding bus transactions; power of 2, at least 2
REG_ADDR_W, 5, width of the destination register address

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active-low
issue_valid  in  1  EX presents a memory operation
issue_ready  out  1  operation consumed this cycle
issue_op  in  3  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW
issue_addr  in  32  virtual address
issue_wdata  in  32  store data (rt)
issue_wd  in  REG_ADDR_W  load destination register
flush  in  1  kill all in-flight operations (exception or eret)
data_req  out  1  bus request
data_wr  out  1  1 = store
data_size  out  2  0 = byte, 1 = half, 2 = word
data_addr  out  32  physical address
data_wdata  out  32  store data, lane-replicated
data_rdata  in  32  read data
data_addr_ok  in  1  request accepted
data_data_ok  in  1  oldest transaction complete
resp_valid  out  1  one-cycle completion pulse
resp_wreg  out  1  1 = write the register file (loads only)
resp_wd  out  REG_ADDR_W  destination register
resp_wdata  out  32  extracted load data
exc_valid  out  1  one-cycle address-error pulse
exc_code  out  5  4 = AdEL, 5 = AdES
exc_badvaddr  out  32  faulting virtual address
outstanding  out  $clog2(DEPTH)+1  live tracking count

Behaviour:
- Reset (async, rst_n = 0): tracking FIFO empty, count 0. All registered outputs are 0: resp_*, exc_*, outstanding.
- Misalignment: LH, LHU, SH need addr[0] = 0. LW, SW need addr[1:0] = 0. Byte operations are never misaligned.
- data_req = issue_valid & aligned & (count < DEPTH) & !flush. The request is combinational from the issue inputs. EX holds the inputs stable until issue_ready.
- issue_ready:
  - aligned operation: data_req & data_addr_ok.
  - misaligned operation: (count == 0) & !flush. This keeps exceptions precise: all older operations drain first.
- Push on data_req & data_addr_ok. The entry holds {op, addr[1:0], wd, killed = 0}.
- Full boundary: when count == DEPTH, data_req = 0, even if a pop occurs in the same cycle.
- Pop on data_data_ok with count > 0. data_ok always refers to the oldest entry. data_ok with count == 0 is ignored and count stays 0.
- Simultaneous push and pop: count is unchanged, and both pointers advance modulo DEPTH.
- Response registered 1 cycle after a pop, only if the entry is not killed:
  - resp_valid = 1.
  - resp_wreg = 1 for loads, 0 for stores.
  - Load extraction by addr[1:0]:
    - LB/LBU select byte lane addr[1:0], sign- or zero-extended.
    - LH/LHU select lane addr[1]·16.
    - LW passes data_rdata unchanged.
- Store data replication: SB replicates the byte ×4, SH replicates the half ×2, SW passes the word.
- data_wr = 1 for ops 5–7. data_size = op-derived.
- Misaligned accept: exc_valid, exc_code and exc_badvaddr = issue_addr are registered 1 cycle later. No bus request is made and no resp_valid is produced.
- Flush:
  - Sets killed on every valid entry.
  - Blocks issue in the same cycle.
  - A pop of a killed entry in the same cycle produces no response.
  - Later data_ok responses still pop entries but produce no resp_valid.
  - New issues may proceed the cycle after flush.
- Reset mid-operation clears the FIFO. Subsequent stray data_ok is ignored as empty.

Optional Feature:
LSU_KSEG_MAP_EN
- Defined: fixed MIPS segment mapping.
  - kseg0 (0x8000_0000–0x9FFF_FFFF) and kseg1 (0xA000_0000–0xBFFF_FFFF) map to data_addr = {3'b000, addr[28:0]}.
  - All other addresses pass through unchanged.
- Undefined: data_addr = issue_addr with no mapping. Alignment checks always use the virtual address.

Test Plan:
1. LW at 0x8000_0010 with addr_ok, then data_ok 2 cycles later with rdata 0xDEAD_BEEF -> resp_valid 1 cycle after data_ok, resp_wdata = 0xDEAD_BEEF, resp_wreg = 1, data_addr = 0x0000_0010 (LSU_KSEG_MAP_EN defined).
2. LB at addr ...03 with rdata 0x80FF_1234, then LBU at addr ...03 -> resp_wdata 0xFFFF_FF80, then 0x0000_0080.
3. Issue 4 loads with addr_ok and no data_ok (DEPTH = 4) -> outstanding = 4, 5th issue_valid gives data_req = 0. A data_ok in the same cycle still keeps data_req = 0 that cycle.
4. SH at 0x...01 with 1 load outstanding -> issue_ready = 0 until the load's data_ok. Then exc_valid with exc_code = 5, exc_badvaddr = 0x...01, and no data_req.
5. 3 loads outstanding, flush pulse, then 3 data_ok -> no resp_valid. An LW issued the next cycle completes normally.
6. rst_n low while 2 loads are outstanding, then a stray data_ok after release -> outputs 0, outstanding = 0, no resp_valid.
